// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequences byte/half/word accesses to the data memory and
// shares it between port 0 (CPU MEM stage) and port 1 (program/debug loader)
// with round-robin arbitration. Misaligned or illegal-size accesses are
// rejected without touching memory. All outputs are registered.
// Optional build macro: DMEM_ARB_STATS_EN adds saturating grant/error counters.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [1:0]        size0,
  input  logic [1:0]        size1,
  input  logic              sext0,
  input  logic              sext1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic              mem_sext,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [1:0]        mem_size,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       err_cnt,
`endif
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // Size 11 is illegal; halves need addr[0]=0, words need addr[1:0]=0.
  function automatic logic illegal_access(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lsb[0];
      2'b10:   bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  state_e              state_q, state_d;
  logic                last_q, last_d;      // last granted port
  logic                gnt_q, gnt_d;        // port owning the current access
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_rw_q, mem_rw_d;
  logic                mem_sext_q, mem_sext_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic [1:0]          mem_size_q, mem_size_d;

  logic                gnt_s;
  logic                sel_we_s;
  logic                sel_sext_s;
  logic [1:0]          sel_size_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                reject_s;

  // Pick the winning port (ties go to the port not granted last) and mux its fields.
  always_comb begin
    if (req0 && req1) begin
      gnt_s = ~last_q;
    end else begin
      gnt_s = req1;
    end
    if (gnt_s) begin
      sel_we_s    = we1;
      sel_sext_s  = sext1;
      sel_size_s  = size1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_sext_s  = sext0;
      sel_size_s  = size0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
    reject_s = illegal_access(sel_size_s, sel_addr_s[1:0]);
  end

  // Next-state and registered-output logic for the IDLE/ACCESS/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata_d      = rdata_q;
    mem_enable_d = 1'b0;
    mem_rw_d     = mem_rw_q;
    mem_sext_d   = mem_sext_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_size_d   = mem_size_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          last_d     = gnt_s;
          gnt_d      = gnt_s;
          mem_rw_d   = sel_we_s;
          mem_sext_d = sel_sext_s;
          mem_addr_d = sel_addr_s;
          mem_din_d  = sel_wdata_s;
          mem_size_d = sel_size_s;
          if (reject_s) begin
            // Rejected: answer straight away, memory is never enabled.
            state_d = S_DONE;
            if (gnt_s) begin
              done1_d = 1'b1;
              err1_d  = 1'b1;
            end else begin
              done0_d = 1'b1;
              err0_d  = 1'b1;
            end
            if (!sel_we_s) begin
              rdata_d = '0;
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
            state_d      = S_ACCESS;
            mem_enable_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        if (!mem_rw_q) begin
          rdata_d = mem_dout;
        end else begin
          rdata_d = rdata_q;
        end
        if (gnt_q) begin
          done1_d = 1'b1;
        end else begin
          done0_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      gnt_q        <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata_q      <= '0;
      mem_enable_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_sext_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_size_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata_q      <= rdata_d;
      mem_enable_q <= mem_enable_d;
      mem_rw_q     <= mem_rw_d;
      mem_sext_q   <= mem_sext_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_size_q   <= mem_size_d;
    end
  end

  assign done0      = done0_q;
  assign done1      = done1_q;
  assign err0       = err0_q;
  assign err1       = err1_q;
  assign rdata      = rdata_q;
  assign mem_enable = mem_enable_q;
  assign mem_rw     = mem_rw_q;
  assign mem_sext   = mem_sext_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_size   = mem_size_q;

`ifdef DMEM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        grant_s;
  logic [15:0] gnt_cnt0_q, gnt_cnt1_q, err_cnt_q;

  assign grant_s = (state_q == S_IDLE) && (req0 || req1);

  // Saturating per-port grant counters and shared reject counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0_q <= 16'h0000;
      gnt_cnt1_q <= 16'h0000;
      err_cnt_q  <= 16'h0000;
    end else if (grant_s) begin
      if (gnt_s) begin
        gnt_cnt1_q <= sat_inc(gnt_cnt1_q);
      end else begin
        gnt_cnt0_q <= sat_inc(gnt_cnt0_q);
      end
      if (reject_s) begin
        err_cnt_q <= sat_inc(err_cnt_q);
      end
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: scoreboard of expected completions,
// a big-endian byte memory model behind the mem_* port, and scenario tasks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [1:0]  size0 = 2'b00, size1 = 2'b00;
  logic        sext0 = 1'b0, sext1 = 1'b0;
  logic [7:0]  addr0 = 8'h00, addr1 = 8'h00;
  logic [31:0] wdata0 = 32'h0, wdata1 = 32'h0;
  logic        done0, done1, err0, err1;
  logic [31:0] rdata;
  logic        mem_enable, mem_rw, mem_sext;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic [1:0]  mem_size;
  logic [31:0] mem_dout;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1, err_cnt;
`endif

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .size0(size0), .size1(size1), .sext0(sext0), .sext1(sext1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1), .rdata(rdata),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_sext(mem_sext),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_size(mem_size),
`ifdef DMEM_ARB_STATS_EN
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .err_cnt(err_cnt),
`endif
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0;
  int rem0 = 0, rem1 = 0;
  bit raise0 = 1'b0, raise1 = 1'b0;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: big-endian bytes, sign extension applied by the memory.
  logic [7:0]  mem_m [256];
  logic        use_model = 1'b1;
  logic [31:0] forced_dout = 32'h0;
  logic [15:0] mh;

  always_comb begin
    mh = {mem_m[mem_addr], mem_m[mem_addr + 8'd1]};
    if (!use_model) begin
      mem_dout = forced_dout;
    end else begin
      case (mem_size)
        2'b00:   mem_dout = mem_sext ? {{24{mem_m[mem_addr][7]}}, mem_m[mem_addr]} : {24'h0, mem_m[mem_addr]};
        2'b01:   mem_dout = mem_sext ? {{16{mh[15]}}, mh} : {16'h0, mh};
        2'b10:   mem_dout = {mh, mem_m[mem_addr + 8'd2], mem_m[mem_addr + 8'd3]};
        default: mem_dout = 32'h0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_enable && mem_rw) begin
      case (mem_size)
        2'b00: mem_m[mem_addr] <= mem_din[7:0];
        2'b01: begin
          mem_m[mem_addr]        <= mem_din[15:8];
          mem_m[mem_addr + 8'd1] <= mem_din[7:0];
        end
        2'b10: begin
          mem_m[mem_addr]        <= mem_din[31:24];
          mem_m[mem_addr + 8'd1] <= mem_din[23:16];
          mem_m[mem_addr + 8'd2] <= mem_din[15:8];
          mem_m[mem_addr + 8'd3] <= mem_din[7:0];
        end
        default: ;
      endcase
    end
  end

  typedef struct {
    int          port;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input int port, input logic we, input logic [1:0] size, input logic sext,
                          input logic [7:0] addr, input logic [31:0] wdata, input logic err,
                          input logic [31:0] rd, input int lat);
    exp_t e;
    e.port = port; e.we = we; e.size = size; e.sext = sext; e.addr = addr;
    e.wdata = wdata; e.err = err; e.rdata = rd;
    e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
    sb.push_back(e);
  endtask

  // Drive a request on one port (called at a negedge) and record its expected completion.
  task automatic issue(input int port, input logic we, input logic [1:0] size, input logic sext,
                       input logic [7:0] addr, input logic [31:0] wdata, input logic err,
                       input logic [31:0] rd, input int lat);
    if (port == 0) begin
      we0 = we; size0 = size; sext0 = sext; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
    end else begin
      we1 = we; size1 = size; sext1 = sext; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
    end
    push_exp(port, we, size, sext, addr, wdata, err, rd, lat);
  endtask

  // Run until the scoreboard empties, checking memory commands and done responses.
  task automatic drain(input int budget);
    int n = 0;
    int p;
    exp_t e;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (raise0) begin req0 = 1'b1; raise0 = 1'b0; end
      if (raise1) begin req1 = 1'b1; raise1 = 1'b0; end
      if (mem_enable) begin
        en_cnt++;
        e = sb[0];
        checks++;
        if (e.err) begin
          failures++;
          $display("FAIL enable_on_reject: mem_enable=1 required 0 (addr %h)", e.addr);
        end
        checks++;
        if (mem_addr !== e.addr || mem_rw !== e.we || mem_size !== e.size || mem_sext !== e.sext ||
            (e.we && mem_din !== e.wdata)) begin
          failures++;
          $display("FAIL mem_cmd: got addr=%h rw=%b size=%b sext=%b din=%h required addr=%h rw=%b size=%b sext=%b din=%h",
                   mem_addr, mem_rw, mem_size, mem_sext, mem_din, e.addr, e.we, e.size, e.sext, e.wdata);
        end
      end
      checks++;
      if (done0 && done1) begin
        failures++;
        $display("FAIL done_both: done0=1 done1=1 required at most one");
      end
      if (done0 || done1) begin
        p = done1 ? 1 : 0;
        e = sb.pop_front();
        checks++;
        if (p != e.port) begin
          failures++;
          $display("FAIL grant_port: got done on port %0d required port %0d", p, e.port);
        end
        checks++;
        if ((p == 1 ? err1 : err0) !== e.err) begin
          failures++;
          $display("FAIL err_flag: got %b required %b (port %0d)", (p == 1 ? err1 : err0), e.err, p);
        end
        if (!e.we) begin
          checks++;
          if (rdata !== e.rdata) begin
            failures++;
            $display("FAIL rdata: got %h required %h (port %0d addr %h)", rdata, e.rdata, p, e.addr);
          end
        end
        if (e.exp_cyc >= 0) begin
          checks++;
          if (cyc != e.exp_cyc) begin
            failures++;
            $display("FAIL latency: done at cycle %0d required %0d", cyc, e.exp_cyc);
          end
        end
        if (p == 0) begin
          req0 = 1'b0;
          if (rem0 > 0) begin rem0--; raise0 = 1'b1; end
        end else begin
          req1 = 1'b0;
          if (rem1 > 0) begin rem1--; raise1 = 1'b1; end
        end
      end
    end
    checks++;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL timeout: %0d completions outstanding after %0d cycles required 0", sb.size(), n);
      sb.delete();
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({done0, done1, err0, err1, rdata, mem_enable, mem_rw, mem_sext, mem_addr, mem_din, mem_size} !== 81'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0",
               {done0, done1, err0, err1, rdata, mem_enable, mem_rw, mem_sext, mem_addr, mem_din, mem_size});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_enable !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet: enable=%b done0=%b done1=%b required 0", mem_enable, done0, done1);
    end
  endtask

  task automatic test_word;
    int e0;
    @(negedge clk);
    e0 = en_cnt;
    issue(0, 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
    drain(20);
    checks++;
    if (en_cnt - e0 != 1) begin failures++; $display("FAIL store_enable_cycles: got %0d required 1", en_cnt - e0); end
    @(negedge clk);
    e0 = en_cnt;
    issue(0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    drain(20);
    checks++;
    if (en_cnt - e0 != 1) begin failures++; $display("FAIL load_enable_cycles: got %0d required 1", en_cnt - e0); end
  endtask

  task automatic test_sext;
    use_model = 1'b0;
    forced_dout = 32'hFFFFFF80;
    @(negedge clk);
    issue(1, 1'b0, 2'b00, 1'b1, 8'h33, 32'h0, 1'b0, 32'hFFFFFF80, 2);
    drain(20);
    forced_dout = 32'h00000080;
    @(negedge clk);
    issue(1, 1'b0, 2'b00, 1'b1, 8'h34, 32'h0, 1'b0, 32'h00000080, 2);
    drain(20);
    use_model = 1'b1;
  endtask

  task automatic test_half;
    @(negedge clk);
    issue(0, 1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 1'b0, 32'hFFFFBEEF, 2);
    drain(20);
    @(negedge clk);
    issue(1, 1'b0, 2'b01, 1'b0, 8'h10, 32'h0, 1'b0, 32'h0000DEAD, 2);
    drain(20);
  endtask

  task automatic test_misaligned;
    int e0;
    e0 = en_cnt;
    @(negedge clk);
    issue(0, 1'b0, 2'b10, 1'b0, 8'h02, 32'h0, 1'b1, 32'h0, 1);
    drain(20);
    @(negedge clk);
    issue(0, 1'b0, 2'b01, 1'b0, 8'h03, 32'h0, 1'b1, 32'h0, 1);
    drain(20);
    @(negedge clk);
    issue(0, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0, 1'b1, 32'h0, 1);
    drain(20);
    @(negedge clk);
    issue(1, 1'b1, 2'b10, 1'b0, 8'h01, 32'hCAFEF00D, 1'b1, 32'h0, 1);
    drain(20);
    checks++;
    if (en_cnt != e0) begin failures++; $display("FAIL reject_enable: got %0d enable cycles required 0", en_cnt - e0); end
  endtask

  // Both ports keep requesting; grants must alternate starting with port 0.
  task automatic test_round_robin;
    @(negedge clk);
    rem0 = 3; rem1 = 3;
    issue(0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    issue(1, 1'b1, 2'b10, 1'b0, 8'h20, 32'h12345678, 1'b0, 32'h0, -1);
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, -1);
      push_exp(1, 1'b1, 2'b10, 1'b0, 8'h20, 32'h12345678, 1'b0, 32'h0, -1);
    end
    drain(100);
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    issue(0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    @(negedge clk);
    checks++;
    if (mem_enable !== 1'b1) begin failures++; $display("FAIL abort_setup: mem_enable=%b required 1", mem_enable); end
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_enable !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL abort: enable=%b done0=%b done1=%b required 0", mem_enable, done0, done1);
    end
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || done1 !== 1'b0 || mem_enable !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet: done0=%b done1=%b enable=%b required 0", done0, done1, mem_enable);
      end
    end
    issue(0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    issue(1, 1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 1'b0, 32'h12345678, -1);
    drain(40);
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    issue(0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    drain(20);
    @(negedge clk);
    issue(0, 1'b0, 2'b11, 1'b0, 8'h10, 32'h0, 1'b1, 32'h0, 1);
    drain(20);
    @(negedge clk);
    issue(1, 1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 1'b0, 32'h12345678, 2);
    drain(20);
    @(negedge clk);
    issue(0, 1'b0, 2'b00, 1'b0, 8'h11, 32'h0, 1'b0, 32'h000000AD, 2);
    drain(20);
    @(negedge clk);
    issue(1, 1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 1'b0, 32'h12345678, 2);
    drain(20);
    @(negedge clk);
    checks++;
    if (gnt_cnt0 !== 16'd3 || gnt_cnt1 !== 16'd2 || err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL stats: got gnt0=%0d gnt1=%0d err=%0d required 3 2 1", gnt_cnt0, gnt_cnt1, err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word();
    test_sext();
    test_half();
    test_misaligned();
    test_round_robin();
    test_reset_mid_access();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences all accesses to the byte-addressed data memory (8-bit address, 32-bit data, byte/half/word size, optional sign extension).
- Shares that memory between two requesters: port 0 is the CPU MEM stage and port 1 is the program/debug loader.
- Fair round-robin arbitration between the two ports.
- Rejects misaligned or illegal-size accesses before they reach memory, and returns registered read data with a one-cycle done pulse.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 32, data width; fixed at 32 because the Size encoding assumes it.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0 / req1  input  1  access request, port 0 / 1.
- we0 / we1  input  1  1 = store, 0 = load.
- size0 / size1  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- sext0 / sext1  input  1  sign-extend load result.
- addr0 / addr1  input  ADDR_W  byte address.
- wdata0 / wdata1  input  32  store data; big-endian byte order, MSB goes to the lowest address.
- done0 / done1  output  1  one-cycle completion pulse.
- err0 / err1  output  1  valid with done; access was rejected.
- rdata  output  32  load result; valid in the done cycle for the port whose done is high.
- mem_enable  output  1  memory Enable.
- mem_rw  output  1  memory ReadWrite (1 = write).
- mem_sext  output  1  memory SignExtend.
- mem_addr  output  ADDR_W  memory Address.
- mem_din  output  32  memory DataIn.
- mem_size  output  2  memory Size.
- mem_dout  input  32  memory DataOut.

Behaviour:
- Reset: all outputs 0; state = IDLE; last-granted pointer = port 1, so port 0 wins the first tie.
- All outputs are registered.

States:
- IDLE
  - Sample req0 and req1.
  - None high: stay in IDLE.
  - One high: grant that port.
  - Both high: grant the port not granted last (round-robin); update the pointer on every grant.
  - On grant, latch that port's we/size/sext/addr/wdata into a command register.
  - Check the latched command:
    - size = 11, or half with addr[0] = 1, or word with addr[1:0] != 0 → go to DONE with error flag set; the memory is never enabled.
    - Otherwise → go to ACCESS, driving mem_* from the command register with mem_enable = 1.
- ACCESS (exactly 1 cycle)
  - mem_enable = 1; mem_* held stable.
  - Load: capture mem_dout into rdata at the end of the cycle.
  - Store: rdata unchanged.
  - Next state: DONE.
- DONE (exactly 1 cycle)
  - mem_enable = 0.
  - doneN = 1 for the granted port; errN = error flag.
  - Loads present the captured rdata; rejected loads present rdata = 0.
  - Next state: IDLE.

Timing and handshake:
- Latency from req sampled in IDLE to done:
  - Legal access: 2 cycles (IDLE → ACCESS → DONE).
  - Rejected access: 1 cycle (IDLE → DONE).
- A requester holds req and its fields stable until it sees done, and deasserts req in the cycle after done.
- A req seen high in IDLE is always a new request, so back-to-back accesses are possible.
- The non-granted port's req stays pending and is not lost.
- Changes to a granted port's fields after the grant are ignored.
- Reset mid-access (ACCESS or DONE): return to IDLE immediately; mem_enable = 0 and done = 0 in the next cycle; the aborted request produces no done.
- done0 and done1 are never high in the same cycle.
- Addresses never wrap: alignment keeps addr+3 within range.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds output ports:
  - gnt_cnt0 [15:0] and gnt_cnt1 [15:0]: count grants per port, including rejected ones.
  - err_cnt [15:0]: counts rejected accesses on both ports.
- All counters are cleared by reset and saturate at 16'hFFFF.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Port 0 word store, addr 8'h10, wdata 32'hDEADBEEF; then a word load of 8'h10 → mem_enable high exactly 1 cycle for each access; done0 2 cycles after req; rdata = 32'hDEADBEEF; err0 = 0.
- Port 1 byte load with sext = 1, where mem_dout = 32'hFFFFFF80 → done1 with rdata = 32'hFFFFFF80; next access by port 1 with mem_dout = 32'h00000080 → rdata = 32'h00000080.
- req0 and req1 high together for 4 consecutive accesses each → grant order 0, 1, 0, 1, …; no port gets two consecutive grants while the other is requesting.
- Misaligned requests: port 0 word at addr 8'h02 → done0 = 1 and err0 = 1 one cycle after req, mem_enable never high; half at 8'h03 and size = 11 → same response.
- reset asserted during ACCESS → next cycle mem_enable = 0, no done pulse, state IDLE; a request after reset is served by port 0 first on a tie.
- With DMEM_ARB_STATS_EN defined: 3 grants to port 0, 2 to port 1, 1 error → gnt_cnt0 = 3, gnt_cnt1 = 2, err_cnt = 1.
